multicycle_sequencer: RTL
=========================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle control FSM for the RV32I core. Steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives instruction-memory and data-memory handshakes.
//  Converts the decoder's static reg_wren/ram_wren levels into single-cycle strobes.
//  Halts on SYSTEM opcodes, illegal opcodes and memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles a req may wait for ready before bus_error (>=1)
//  CNT_W        32   width of retire_count
// PORTS
//  clk              in   1      single clock; all state changes on rising edge
//  rstn             in   1      synchronous, active-low reset
//  opcode           in   7      IR[6:0], valid from DECODE onward
//  dec_reg_wren     in   1      decoder reg_wren level
//  dec_ram_wren     in   1      decoder ram_wren level (1 = store)
//  dec_reg_wdata_src in  1      decoder reg_write_data_src (1 = RAM, i.e. load)
//  imem_req         out  1      instruction fetch request
//  imem_ready       in   1      fetch data valid; sampled only while imem_req=1
//  ir_wren          out  1      load IR (= imem_req & imem_ready)
//  dmem_req         out  1      data memory request
//  dmem_ready       in   1      data access done; sampled only while dmem_req=1
//  ram_wren         out  1      store strobe (= dmem_req & dec_ram_wren)
//  reg_wren         out  1      register file write strobe
//  pc_wren          out  1      PC update strobe
//  halted           out  1      sticky; FSM is in HALT
//  illegal          out  1      sticky; halt cause = illegal opcode
//  bus_error        out  1      sticky; halt cause = memory timeout
//  retire_count     out  CNT_W  retired instructions, wraps modulo 2^CNT_W
//  state            out  3      current state (debug)
// BEHAVIOUR
//  - States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6.
//  - Reset (rstn=0 at edge): state<=IDLE; wait counter, retire_count, halted,
//    illegal and bus_error <=0. All outputs read 0 while in IDLE.
//    Reset mid-operation drops any outstanding req with no strobe.
//  - IDLE: lasts 1 cycle, then ->FETCH.
//  - FETCH: imem_req=1 until imem_ready. Ready in the same cycle -> ir_wren=1,
//    ->DECODE. A 0-wait fetch occupies 1 cycle.
//  - DECODE (1 cycle):
//    - opcode in {0110011,0010011,0000011,0100011,1100011,1101111,1100111,
//      0110111,0010111} ->EXEC.
//    - 1110011 (SYSTEM) ->HALT with illegal=0.
//    - Any other opcode ->HALT with illegal=1.
//  - EXEC (1 cycle): load (dec_reg_wdata_src=1) or store (dec_ram_wren=1) ->MEM;
//    otherwise ->WB.
//  - MEM: dmem_req=1 until dmem_ready; ram_wren follows the rule above. On ready ->WB.
//  - WB (1 cycle): reg_wren=dec_reg_wren, pc_wren=1, retire_count+=1, ->FETCH.
//  - Latency: non-memory instruction = 4 cycles; load/store = 5 cycles (0-wait memory).
//  - Timeout: wait counter clears on entry to FETCH/MEM and increments each cycle
//    that ready=0. When it reaches MEM_TIMEOUT with ready=0 -> bus_error=1, ->HALT,
//    no strobe. Ready in the same cycle as the limit wins: normal progress, no error.
//  - HALT: absorbing until reset. halted=1; all reqs and strobes 0; ready ignored.
//  - ready while req=0 is ignored. Strobes are single-cycle and never overlap;
//    reg_wren and ram_wren are never both 1.
// STRUCTURE
//  - State codes CTRL_STATE_* and the opcode constants go in the shared define
//    file, next to the existing OPCODE_* macros; no local literals.
//  - One sub-module: mem_wait_timer (clear, count enable, MEM_TIMEOUT compare,
//    expired flag), shared by FETCH and MEM.
//  - Next-state and output logic are combinational from state plus inputs;
//    state, counters and sticky flags are registered.
// TESTING
//  1. add (IR=0x00208033, imem_ready tied 1) -> ir_wren in cycle 1 after IDLE;
//     reg_wren=1 and pc_wren=1 together in cycle 4; retire_count=1.
//  2. lw (opcode 0000011, dec_reg_wdata_src=1), dmem_ready high on 4th req cycle
//     -> dmem_req high 4 cycles; ram_wren=0 throughout; reg_wren=1 only in WB.
//  3. sw (opcode 0100011, dec_ram_wren=1, dec_reg_wren=0) -> ram_wren=1 exactly while
//     dmem_req=1; WB has reg_wren=0, pc_wren=1.
//  4. opcode 7'h7F -> HALT after DECODE: illegal=1, halted=1; no imem_req for
//     100 cycles even with imem_ready=1. ecall 7'h73 -> halted=1, illegal=0.
//  5. MEM_TIMEOUT=4, dmem_ready stuck 0 -> bus_error=1 after 4 MEM cycles, no strobes.
//     Repeat with ready on the 4th cycle -> WB, bus_error=0.
//  6. rstn=0 for 1 cycle during MEM with retire_count=7 -> next state IDLE; all
//     outputs 0; retire_count=0; fetch resumes 1 cycle after rstn=1.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared state encodings and RV32I major-opcode constants for the multi-cycle
// control path.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    CTRL_STATE_IDLE   = 3'd0,
    CTRL_STATE_FETCH  = 3'd1,
    CTRL_STATE_DECODE = 3'd2,
    CTRL_STATE_EXEC   = 3'd3,
    CTRL_STATE_MEM    = 3'd4,
    CTRL_STATE_WB     = 3'd5,
    CTRL_STATE_HALT   = 3'd6
  } ctrl_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  function automatic logic is_exec_opcode(input logic [6:0] op);
    case (op)
      OPCODE_OP, OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
      OPCODE_JAL, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer (master)
// and the memory side (slave).
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic ir_wren;
  logic dmem_req;
  logic dmem_ready;
  logic ram_wren;

  modport master (
    output imem_req, ir_wren, dmem_req, ram_wren,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, ir_wren, dmem_req, ram_wren,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Wait-state counter shared by FETCH and MEM; flags the cycle in which a request
// has gone MEM_TIMEOUT cycles without ready.
module multicycle_sequencer_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic en,
  input  logic ready,
  output logic expired
);
  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !ready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Ready arriving in the limit cycle masks expiry.
  assign expired = en && !ready && (cnt_q == LIMIT_M1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core; turns
// decoder write-enable levels into single-cycle strobes and halts on faults.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [6:0]            opcode,
  input  logic                  dec_reg_wren,
  input  logic                  dec_ram_wren,
  input  logic                  dec_reg_wdata_src,
  multicycle_sequencer_if.master bus,
  output logic                  reg_wren,
  output logic                  pc_wren,
  output logic                  halted,
  output logic                  illegal,
  output logic                  bus_error,
  output logic [CNT_W-1:0]      retire_count,
  output logic [2:0]            state
);
  ctrl_state_e      state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             bus_error_q, bus_error_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             timer_en, timer_ready, timer_expired;

  multicycle_sequencer_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (state_d != state_q),
    .en      (timer_en),
    .ready   (timer_ready),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus_error_d   = bus_error_q;
    retire_d      = retire_q;
    timer_en      = 1'b0;
    timer_ready   = 1'b0;
    bus.imem_req  = 1'b0;
    bus.ir_wren   = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.ram_wren  = 1'b0;
    reg_wren      = 1'b0;
    pc_wren       = 1'b0;
    case (state_q)
      CTRL_STATE_IDLE: state_d = CTRL_STATE_FETCH;
      CTRL_STATE_FETCH: begin
        bus.imem_req = 1'b1;
        timer_en     = 1'b1;
        timer_ready  = bus.imem_ready;
        if (bus.imem_ready) begin
          bus.ir_wren = 1'b1;
          state_d     = CTRL_STATE_DECODE;
        end else if (timer_expired) begin
          bus_error_d = 1'b1;
          state_d     = CTRL_STATE_HALT;
        end
      end
      CTRL_STATE_DECODE: begin
        if (is_exec_opcode(opcode)) begin
          state_d = CTRL_STATE_EXEC;
        end else begin
          illegal_d = (opcode != OPCODE_SYSTEM);
          state_d   = CTRL_STATE_HALT;
        end
      end
      CTRL_STATE_EXEC:
        state_d = (dec_reg_wdata_src || dec_ram_wren) ? CTRL_STATE_MEM : CTRL_STATE_WB;
      CTRL_STATE_MEM: begin
        bus.dmem_req = 1'b1;
        bus.ram_wren = dec_ram_wren;
        timer_en     = 1'b1;
        timer_ready  = bus.dmem_ready;
        if (bus.dmem_ready) begin
          state_d = CTRL_STATE_WB;
        end else if (timer_expired) begin
          bus_error_d = 1'b1;
          state_d     = CTRL_STATE_HALT;
        end
      end
      CTRL_STATE_WB: begin
        reg_wren = dec_reg_wren;
        pc_wren  = 1'b1;
        retire_d = retire_q + CNT_W'(1);
        state_d  = CTRL_STATE_FETCH;
      end
      CTRL_STATE_HALT: state_d = CTRL_STATE_HALT;
      default:         state_d = CTRL_STATE_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= CTRL_STATE_IDLE;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      retire_q    <= '0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
      retire_q    <= retire_d;
    end
  end

  assign halted       = (state_q == CTRL_STATE_HALT);
  assign illegal      = illegal_q;
  assign bus_error    = bus_error_q;
  assign retire_count = retire_q;
  assign state        = state_q;
endmodule
